// File: rtl/arbitro_es_pkg.sv
// arbitro_es_pkg: shared types and defaults for the I/O port bus arbiter.
package arbitro_es_pkg;

    localparam int AW_DEF      = 7;
    localparam int DW_DEF      = 8;
    localparam int NUM_DISP_IO = 5;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        FIN
    } estado_t;

endpackage

// File: rtl/arbitro_entrada_salida_selector.sv
// selector_prioridad: combinational one-hot picker. Scans upward from the
// start pointer (wrapping) and picks the first active requester.
module selector_prioridad #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] sel_o,
    output logic [PW-1:0]   idx_o,
    output logic            hay_o
);

    int j;

    // first requester at or after ptr_i wins
    always_comb begin
        sel_o = '0;
        idx_o = '0;
        hay_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!hay_o && req_i[j]) begin
                sel_o[j] = 1'b1;
                idx_o    = PW'(j);
                hay_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_entrada_salida.sv
// arbitro_entrada_salida: arbiter/sequencer for the memory-mapped I/O port
// bus. One transaction in flight; each ends with a one-cycle done pulse.
// Optional build macro ARBITRO_ES_ROUND_ROBIN_EN selects rotating priority;
// without it the lowest index always wins and no pointer register exists.
module arbitro_entrada_salida
    import arbitro_es_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      io_dir,
    output logic [DW-1:0]      io_wdata,
    output logic               io_activar,
    output logic               io_escribir,
    input  logic [DW-1:0]      io_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    estado_t         estado_q;
    logic [NREQ-1:0] gnt_q, done_q;
    logic [DW-1:0]   rdata_q, io_wdata_q;
    logic [AW-1:0]   io_dir_q;
    logic            io_activar_q, io_escribir_q;

    logic [NREQ-1:0] sel;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   ptr;
    logic            hay_req;

    selector_prioridad #(.NREQ(NREQ), .PW(PW)) u_sel (
        .req_i (req),
        .ptr_i (ptr),
        .sel_o (sel),
        .idx_o (sel_idx),
        .hay_o (hay_req)
    );

`ifdef ARBITRO_ES_ROUND_ROBIN_EN
    logic [PW-1:0] ptr_q, ptr_d;

    assign ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
    assign ptr   = ptr_q;

    // move priority past each winner so the last winner is served last
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else if (estado_q == IDLE && hay_req)
            ptr_q <= ptr_d;
    end
`else
    assign ptr = '0;
`endif

    // Transaction sequencer. The bus registers io_dir/io_wdata are loaded
    // straight from the winner in IDLE and double as the frozen request
    // latch, so later changes on addr/wdata/req cannot disturb the cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q      <= IDLE;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            io_dir_q      <= '0;
            io_wdata_q    <= '0;
            io_activar_q  <= 1'b0;
            io_escribir_q <= 1'b0;
        end else begin
            done_q <= '0;
            case (estado_q)
                IDLE: begin
                    if (hay_req) begin
                        gnt_q        <= sel;
                        io_dir_q     <= addr[sel_idx*AW +: AW];
                        io_activar_q <= 1'b1;
                        if (we[sel_idx]) begin
                            io_escribir_q <= 1'b1;
                            io_wdata_q    <= wdata[sel_idx*DW +: DW];
                            estado_q      <= WR;
                        end else begin
                            estado_q <= RD1;
                        end
                    end
                end
                WR: begin
                    io_activar_q  <= 1'b0;
                    io_escribir_q <= 1'b0;
                    done_q        <= gnt_q;
                    estado_q      <= FIN;
                end
                // I/O block registers its read data at the end of RD1
                RD1: estado_q <= RD2;
                RD2: begin
                    rdata_q      <= io_rdata;
                    io_activar_q <= 1'b0;
                    done_q       <= gnt_q;
                    estado_q     <= FIN;
                end
                FIN: begin
                    gnt_q    <= '0;
                    estado_q <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign io_dir      = io_dir_q;
    assign io_wdata    = io_wdata_q;
    assign io_activar  = io_activar_q;
    assign io_escribir = io_escribir_q;

endmodule

// File: tb/tb_arbitro_entrada_salida.sv
// tb_arbitro_entrada_salida: scoreboard bench with an I/O block model and a
// transaction-level reference (service order, memory contents).
module tb_arbitro_entrada_salida;

    localparam int NREQ = 3;
    localparam int AW   = 7;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req, we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt, done;
    logic [DW-1:0]      rdata, io_wdata, io_rdata;
    logic [AW-1:0]      io_dir;
    logic               io_activar, io_escribir;

    arbitro_entrada_salida #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .io_dir(io_dir), .io_wdata(io_wdata),
        .io_activar(io_activar), .io_escribir(io_escribir), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        we;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0, n_pass = 0;
    int         act_cnt = 0, ndone = 0;
    int         mptr = 0;
    logic [7:0] refmem [128];
    logic [7:0] iomem  [128];

    function automatic logic [7:0] mem_init(int i);
        return 8'(i * 59 + 1);
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    // I/O block: registered read data, write on the enable+strobe edge
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) iomem[i] <= mem_init(i);
        end else if (io_activar && io_escribir) begin
            iomem[io_dir] <= io_wdata;
        end else if (io_activar) begin
            io_rdata <= iomem[io_dir];
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 128; i++) refmem[i] = mem_init(i);
        mptr = 0;
    endfunction

    function automatic int pick(logic [NREQ-1:0] pend);
`ifdef ARBITRO_ES_ROUND_ROBIN_EN
        for (int k = 0; k < NREQ; k++)
            if (pend[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (pend[k]) return k;
`endif
        return -1;
    endfunction

    function automatic void advance_ptr(int w);
        mptr = (w + 1) % NREQ;
    endfunction

    function automatic void expect_entry(int w);
        exp_t e;
        e.idx   = w;
        e.we    = we[w];
        e.addr  = addr[w*AW +: AW];
        e.wdata = wdata[w*DW +: DW];
        if (e.we) refmem[e.addr] = e.wdata;
        e.rdata = e.we ? 8'h00 : refmem[e.addr];
        sbq.push_back(e);
    endfunction

    function automatic void model_grant(int w);
        expect_entry(w);
        advance_ptr(w);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            act_cnt = 0;
        end else begin
            if (!io_activar) chk("escribir_idle", {31'b0, io_escribir}, 0);
            if (!io_activar && done == '0) chk("gnt_idle", {29'b0, gnt}, 0);
            if (io_activar) begin
                act_cnt++;
                if (sbq.size() == 0) chk("bus_unexpected", 1, 0);
                else begin
                    chk("bus_dir", {25'b0, io_dir}, {25'b0, sbq[0].addr});
                    chk("bus_esc", {31'b0, io_escribir}, {31'b0, sbq[0].we});
                    if (sbq[0].we) chk("bus_wdata", {24'b0, io_wdata}, {24'b0, sbq[0].wdata});
                    chk("bus_gnt", {29'b0, gnt}, 32'(1) << sbq[0].idx);
                end
            end
            if (done != '0) begin
                if (sbq.size() == 0) chk("done_unexpected", {29'b0, done}, 0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_who", {29'b0, done}, 32'(1) << e.idx);
                    chk("fin_gnt", {29'b0, gnt}, 32'(1) << e.idx);
                    chk("bus_cycles", act_cnt, e.we ? 1 : 2);
                    if (!e.we) chk("rdata", {24'b0, rdata}, {24'b0, e.rdata});
                end
                ndone++;
                act_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_fields(int i, logic w, logic [6:0] a, logic [7:0] d);
        we[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_done(int i, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done[i] && cnt < 20);
        req[i] = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_phase();
        logic [NREQ-1:0] mask, pend;
        int cyc, w;
        mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++)
            set_fields(i, 1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom));
        pend = mask;
        while (pend != '0) begin
            w = pick(pend);
            model_grant(w);
            pend[w] = 1'b0;
        end
        @(negedge clk);
        req = mask;
        pend = mask;
        cyc = 0;
        while (pend != '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++)
                if (done[i]) begin
                    req[i] = 1'b0;
                    pend[i] = 1'b0;
                end
        end
        if (pend != '0) chk("phase_timeout", {29'b0, pend}, 0);
        req = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt, n0;
        req = '0; we = '0; addr = '0; wdata = '0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_gnt", {29'b0, gnt}, 0);
        chk("rst_done", {29'b0, done}, 0);
        chk("rst_bus", {16'b0, io_dir, io_wdata, io_activar, io_escribir}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single write
        set_fields(0, 1'b1, 7'd3, 8'hA5);
        model_grant(0);
        req[0] = 1'b1;
        wait_done(0, cnt);
        chk("wr_latency", cnt, 2);
        repeat (2) @(negedge clk);

        // single read, I/O block holds 3C at address 1
        set_fields(1, 1'b0, 7'd1, 8'h00);
        model_grant(1);
        req[1] = 1'b1;
        wait_done(1, cnt);
        chk("rd_latency", cnt, 3);
        chk("rd_data", {24'b0, rdata}, 32'h3C);
        repeat (2) @(negedge clk);

        // reset while in RD2
        set_fields(0, 1'b0, 7'd2, 8'h00);
        expect_entry(0);
        req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_gnt", {29'b0, gnt}, 0);
        chk("abort_rdata", {24'b0, rdata}, 0);
        chk("abort_bus", {16'b0, io_dir, io_wdata, io_activar, io_escribir}, 0);
        model_reset();
        advance_ptr(0);
        n0 = ndone;
        repeat (2) @(negedge clk);
        chk("abort_no_done", ndone - n0, 0);
        reset = 1'b0;
        wait_done(0, cnt);
        chk("rerun_latency", cnt, 3);
        repeat (2) @(negedge clk);

        // two masters holding requests continuously
        apply_reset();
        set_fields(0, 1'b1, 7'd6, 8'($urandom));
        set_fields(1, 1'b0, 7'd6, 8'h00);
        for (int t = 0; t < 4; t++) model_grant(pick(3'b011));
        @(negedge clk);
        req = 3'b011;
        n0 = ndone;
        cnt = 0;
        while (ndone - n0 < 4 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        req = '0;
        chk("held_count", ndone - n0, 4);
        repeat (3) @(negedge clk);

        // request dropped and address changed during WR
        set_fields(0, 1'b1, 7'd5, 8'h5A);
        model_grant(0);
        req[0] = 1'b1;
        n0 = ndone;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        addr[0*AW +: AW] = 7'd9;
        repeat (8) @(negedge clk);
        chk("latch_one_done", ndone - n0, 1);

        for (int p = 0; p < 40; p++) run_phase();

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
